// File: rtl/goertzel_bin_scheduler_if.sv
// Sample-stream handshake between a sample source and goertzel_bin_scheduler.
//   s_valid : source has a sample word on s_x
//   s_ready : scheduler accepts the word on this cycle
//   s_x     : CHANELS packed samples, channel 0 in the LSBs
// master = sample source, slave = scheduler.
interface goertzel_bin_scheduler_if #(
  parameter int X_WIDTH = 16,
  parameter int CHANELS = 2
);
  logic                         s_valid;
  logic                         s_ready;
  logic [CHANELS*X_WIDTH-1:0]   s_x;

  modport master (output s_valid, output s_x, input s_ready);
  modport slave  (input s_valid, input s_x, output s_ready);
endinterface

// File: rtl/goertzel_bin_scheduler.sv
// Frame-buffering sequencer for a single-bin serial Goertzel engine.
// Captures one frame of samples (FILL), then replays it to the engine once per
// frequency bin (RUN), with a one-cycle gap (DRAIN) per bin in which the engine
// result is tagged with its bin index.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   s_if (slave)         sample stream: s_valid / s_ready / s_x
//   cfg_we, cfg_bin,
//   cfg_w_re, cfg_w_im   coefficient table write port
//   eng_valid, eng_x,
//   eng_w_re, eng_w_im   to engine valid_i / x / w_re / w_im
//   eng_valid_o          from engine valid_o
//   res_valid, res_bin,
//   res_last             result tag for the engine re/im outputs
//   busy                 high in RUN or DRAIN
//   seq_err              sticky: engine valid_o seen outside DRAIN
module goertzel_bin_scheduler #(
  parameter int X_WIDTH      = 16,
  parameter int W_WIDTH      = 16,
  parameter int CHANELS      = 2,
  parameter int FRAME_LENGTH = 64,
  parameter int N_BINS       = 4,
  localparam int BW = (N_BINS > 1) ? $clog2(N_BINS) : 1,
  localparam int XW = CHANELS * X_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  goertzel_bin_scheduler_if.slave   s_if,
  input  logic                      cfg_we,
  input  logic [BW-1:0]             cfg_bin,
  input  logic signed [W_WIDTH-1:0] cfg_w_re,
  input  logic signed [W_WIDTH-1:0] cfg_w_im,
  output logic                      eng_valid,
  output logic [XW-1:0]             eng_x,
  output logic signed [W_WIDTH-1:0] eng_w_re,
  output logic signed [W_WIDTH-1:0] eng_w_im,
  input  logic                      eng_valid_o,
  output logic                      res_valid,
  output logic [BW-1:0]             res_bin,
  output logic                      res_last,
  output logic                      busy,
  output logic                      seq_err
);

  localparam int AW = $clog2(FRAME_LENGTH);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LENGTH - 1);
  localparam logic [BW-1:0] LAST_BIN = BW'(N_BINS - 1);
  localparam logic [BW:0]   NUM_BIN  = (BW + 1)'(N_BINS);

  logic [1:0]                state;
  logic [AW-1:0]             wr_cnt;
  logic [AW-1:0]             rd_cnt;
  logic [BW-1:0]             bin;
  logic [BW-1:0]             nxt_bin;
  logic [XW-1:0]             buf_mem [FRAME_LENGTH];
  logic signed [W_WIDTH-1:0] tbl_re  [N_BINS];
  logic signed [W_WIDTH-1:0] tbl_im  [N_BINS];
  logic signed [W_WIDTH-1:0] act_re;
  logic signed [W_WIDTH-1:0] act_im;
  logic                      seq_err_r;
  logic                      fill_hs;
  logic                      cfg_hit;

  assign fill_hs = (state == FILL) && s_if.s_valid;
  // Out-of-range table addresses are dropped rather than aliased.
  assign cfg_hit = cfg_we && ({1'b0, cfg_bin} < NUM_BIN);
  assign nxt_bin = bin + BW'(1);

  // Sample buffer: data only, contents survive reset.
  always_ff @(posedge clk) begin
    if (fill_hs) begin
      buf_mem[wr_cnt] <= s_if.s_x;
    end
  end

  // Coefficient table. Loads into act_re/act_im read the pre-write value when
  // a write and a load hit the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_BINS; i++) begin
        tbl_re[i] <= '0;
        tbl_im[i] <= '0;
      end
    end else if (cfg_hit) begin
      tbl_re[cfg_bin] <= cfg_w_re;
      tbl_im[cfg_bin] <= cfg_w_im;
    end
  end

  // Sequencer: FILL -> (RUN -> DRAIN) x N_BINS -> FILL.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bin       <= '0;
      act_re    <= '0;
      act_im    <= '0;
      seq_err_r <= 1'b0;
    end else begin
      if (eng_valid_o && (state != DRAIN)) begin
        seq_err_r <= 1'b1;
      end
      case (state)
        FILL: begin
          if (s_if.s_valid) begin
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              bin    <= '0;
              act_re <= tbl_re[0];
              act_im <= tbl_im[0];
              state  <= RUN;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        RUN: begin
          // No gaps: the engine counts valid cycles to find the frame end.
          if (rd_cnt == LAST_IDX) begin
            rd_cnt <= '0;
            state  <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + AW'(1);
          end
        end
        DRAIN: begin
          if (bin == LAST_BIN) begin
            state <= FILL;
          end else begin
            bin    <= nxt_bin;
            act_re <= tbl_re[nxt_bin];
            act_im <= tbl_im[nxt_bin];
            state  <= RUN;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign s_if.s_ready = (state == FILL);
  assign eng_valid    = (state == RUN);
  assign eng_x        = buf_mem[rd_cnt];
  assign eng_w_re     = act_re;
  assign eng_w_im     = act_im;
  assign res_valid    = (state == DRAIN) && eng_valid_o;
  assign res_bin      = bin;
  assign res_last     = res_valid && (bin == LAST_BIN);
  assign busy         = (state != FILL);
  assign seq_err      = seq_err_r;

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
module tb_goertzel_bin_scheduler;
  localparam int XW = 16;
  localparam int WW = 16;
  localparam int CH = 1;
  localparam int L  = 4;
  localparam int NB = 3;
  localparam int BW = 2;

  typedef struct {
    int          cyc;
    logic [15:0] x;
    logic [15:0] wre;
    logic [15:0] wim;
  } run_t;

  typedef struct {
    int          cyc;
    int          bin;
    bit          last;
    logic [15:0] wre;
    logic [15:0] wim;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  goertzel_bin_scheduler_if #(.X_WIDTH(XW), .CHANELS(CH)) s_if ();

  logic                 cfg_we = 1'b0;
  logic [BW-1:0]        cfg_bin = '0;
  logic signed [WW-1:0] cfg_w_re = '0;
  logic signed [WW-1:0] cfg_w_im = '0;
  logic                 eng_valid;
  logic [CH*XW-1:0]     eng_x;
  logic signed [WW-1:0] eng_w_re;
  logic signed [WW-1:0] eng_w_im;
  logic                 eng_valid_o;
  logic                 res_valid;
  logic [BW-1:0]        res_bin;
  logic                 res_last;
  logic                 busy;
  logic                 seq_err;

  goertzel_bin_scheduler #(
    .X_WIDTH(XW), .W_WIDTH(WW), .CHANELS(CH), .FRAME_LENGTH(L), .N_BINS(NB)
  ) dut (
    .clk(clk), .rstn(rstn), .s_if(s_if),
    .cfg_we(cfg_we), .cfg_bin(cfg_bin), .cfg_w_re(cfg_w_re), .cfg_w_im(cfg_w_im),
    .eng_valid(eng_valid), .eng_x(eng_x), .eng_w_re(eng_w_re), .eng_w_im(eng_w_im),
    .eng_valid_o(eng_valid_o), .res_valid(res_valid), .res_bin(res_bin),
    .res_last(res_last), .busy(busy), .seq_err(seq_err)
  );

  // Minimal engine stand-in: after L valid cycles it raises valid_o for one cycle.
  logic stub_vo;
  logic force_vo = 1'b0;
  int   ecnt;
  always @(posedge clk) begin
    if (!rstn) begin
      ecnt    <= 0;
      stub_vo <= 1'b0;
    end else begin
      stub_vo <= 1'b0;
      if (eng_valid) begin
        if (ecnt == L - 1) begin
          ecnt    <= 0;
          stub_vo <= 1'b1;
        end else begin
          ecnt <= ecnt + 1;
        end
      end
    end
  end
  assign eng_valid_o = stub_vo | force_vo;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model state
  logic [15:0]        fr [L];
  logic signed [15:0] m_re [NB];
  logic signed [15:0] m_im [NB];
  bit                 exp_seq = 1'b0;
  run_t               exp_run [$];
  res_t               exp_res [$];

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rstn) begin
      exp_run.delete();
      exp_res.delete();
    end else begin
      chk("s_ready_vs_busy", s_if.s_ready, !busy);
      chk("seq_err", seq_err, exp_seq);
      if (eng_valid) begin
        if (exp_run.size() == 0) begin
          chk("unexpected_eng_valid", 1, 0);
        end else begin
          run_t e;
          e = exp_run.pop_front();
          chk("run_cycle", cyc, e.cyc);
          chk("eng_x", eng_x, e.x);
          chk("eng_w_re", eng_w_re, $signed(e.wre));
          chk("eng_w_im", eng_w_im, $signed(e.wim));
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_res_valid", 1, 0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("res_cycle", cyc, r.cyc);
          chk("res_bin", res_bin, r.bin);
          chk("res_last", res_last, r.last);
          chk("drain_w_re", eng_w_re, $signed(r.wre));
          chk("drain_w_im", eng_w_im, $signed(r.wim));
        end
      end else begin
        chk("res_last_idle", res_last, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input int b, input logic signed [15:0] re, input logic signed [15:0] im);
    cfg_we   = 1'b1;
    cfg_bin  = BW'(b);
    cfg_w_re = re;
    cfg_w_im = im;
    tick();
    cfg_we = 1'b0;
    if (b < NB) begin
      m_re[b] = re;
      m_im[b] = im;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
  endtask

  // Offer one sample; t = cycle of the accepting handshake (-1 on timeout).
  task automatic send(input logic [15:0] x, output int t);
    s_if.s_valid = 1'b1;
    s_if.s_x     = x;
    t = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_if.s_ready) t = cyc;
      tick();
      if (t >= 0) break;
    end
    if (t < 0) chk("send_timeout", 1, 0);
    s_if.s_valid = 1'b0;
  endtask

  // Feed fr[] as one frame; on completion predict every bin's replay and result.
  task automatic run_frame(input int gap_pos, input int gap_len, output int t_first, output int t_last);
    int t;
    t_first = -1;
    t_last  = -1;
    for (int i = 0; i < L; i++) begin
      if (i == gap_pos) repeat (gap_len) tick();
      send(fr[i], t);
      if (i == 0) t_first = t;
      t_last = t;
    end
    if (t_last >= 0) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < L; i++) begin
          exp_run.push_back('{cyc: t_last + b * (L + 1) + 1 + i, x: fr[i], wre: m_re[b], wim: m_im[b]});
        end
        exp_res.push_back('{cyc: t_last + (b + 1) * (L + 1), bin: b, last: (b == NB - 1),
                            wre: m_re[b], wim: m_im[b]});
      end
    end
  endtask

  task automatic wait_ready(input int exp_c);
    int got;
    got = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_if.s_ready) begin
        got = cyc;
        break;
      end
    end
    chk("ready_return_cycle", got, exp_c);
    tick();
  endtask

  task automatic rand_frame();
    for (int i = 0; i < L; i++) fr[i] = 16'($urandom);
  endtask

  task automatic rand_table();
    for (int b = 0; b < NB; b++) cfg_write(b, 16'($urandom), 16'($urandom));
  endtask

  localparam int PERIOD = NB * (L + 1);

  initial begin
    int tf, tl, prev;
    s_if.s_valid = 1'b0;
    s_if.s_x     = '0;
    model_reset();

    // Reset and idle
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_if.s_ready, 1);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_bin", res_bin, 0);
    chk("rst_w_re", eng_w_re, 0);
    chk("rst_w_im", eng_w_im, 0);
    tick();
    repeat (5) tick();

    // Basic frame
    cfg_write(0, 16'sd1024, 16'sd0);
    cfg_write(1, 16'sd0, 16'sd1024);
    cfg_write(2, -16'sd724, 16'sd724);
    fr[0] = 16'd1; fr[1] = 16'd2; fr[2] = 16'd3; fr[3] = 16'd4;
    run_frame(-1, 0, tf, tl);
    wait_ready(tl + PERIOD + 1);

    // Same samples with 3 idle cycles between samples 2 and 3
    run_frame(2, 3, tf, tl);
    wait_ready(tl + PERIOD + 1);

    // Coefficient writes while the frame is being processed
    rand_frame();
    run_frame(-1, 0, tf, tl);
    cfg_write(0, 16'sd512, 16'sd512);
    cfg_write(3, 16'sd77, -16'sd77);
    wait_cyc(tl + L + 1);
    cfg_write(1, 16'sd300, -16'sd300);
    wait_ready(tl + PERIOD + 1);
    rand_frame();
    run_frame(-1, 0, tf, tl);
    wait_ready(tl + PERIOD + 1);

    // Back-to-back frames with s_valid held high between them
    rand_table();
    prev = -1;
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      run_frame(-1, 0, tf, tl);
      if (prev >= 0) chk("held_accept_cycle", tf, prev + PERIOD + 1);
      prev = tl;
    end
    wait_ready(prev + PERIOD + 1);

    // Random frames with random gaps
    for (int f = 0; f < 4; f++) begin
      rand_table();
      rand_frame();
      run_frame($urandom_range(0, L - 1), $urandom_range(1, 3), tf, tl);
      wait_ready(tl + PERIOD + 1);
    end

    // Reset in the middle of bin 1
    rand_table();
    rand_frame();
    run_frame(-1, 0, tf, tl);
    wait_cyc(tl + 7);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_if.s_ready, 1);
    chk("midrst_w_re", eng_w_re, 0);
    tick();
    repeat (3) tick();
    rand_table();
    rand_frame();
    run_frame(-1, 0, tf, tl);
    wait_ready(tl + PERIOD + 1);

    // Engine valid_o outside DRAIN
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    exp_seq  = 1'b1;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    rstn    = 1'b1;
    exp_seq = 1'b0;
    model_reset();
    repeat (3) tick();

    chk("leftover_run", exp_run.size(), 0);
    chk("leftover_res", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
